// File: rtl/dmrs_pkg.sv
// dmrs_pkg: shared widths, FSM states and the Q0.15 cyclic-shift phase table for dmrs_phase_gen.
package dmrs_pkg;
    localparam int PHASE_W_DEF = 15;
    localparam int NZC_W_DEF   = 11;
    localparam int LEN_W_DEF   = 12;
    localparam int RECIP_W_DEF = 20;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    // round(i * 32768 / 12): phase of cyclic shift i in turns
    localparam logic [14:0] CS_TAB [12] = '{
        15'd0,     15'd2731,  15'd5461,  15'd8192,
        15'd10923, 15'd13653, 15'd16384, 15'd19115,
        15'd21845, 15'd24576, 15'd27307, 15'd30037
    };
endpackage

// File: rtl/dmrs_mod_add.sv
// dmrs_mod_add: (a + b) mod n for a, b < n using one add and one conditional subtract.
module dmrs_mod_add #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] y
);
    logic [W:0] s;
    assign s = {1'b0, a} + {1'b0, b};
    assign y = W'(s >= {1'b0, n} ? s - {1'b0, n} : s);
endmodule

// File: rtl/dmrs_phase_gen.sv
// dmrs_phase_gen: Zadoff-Chu DMRS phase sequence generator with ready/valid output.
// Define DMRS_PHASE_CS_EN to add the cyclic-shift (n_cs) phase term.
module dmrs_phase_gen
    import dmrs_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int NZC_W   = NZC_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int RECIP_W = RECIP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NZC_W-1:0]   q,
    input  logic [NZC_W-1:0]   n_zc,
    input  logic [RECIP_W-1:0] recip_nzc,
    input  logic [LEN_W-1:0]   m_len,
    input  logic [3:0]         n_cs,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    input  logic               phase_ready,
    output logic               last,
    output logic               busy,
    output logic               done
);
    localparam int PW = NZC_W + RECIP_W;
    localparam int SH = RECIP_W - PHASE_W;
    localparam logic [PW-1:0] HALF = PW'(1) << (SH - 1);

    state_t st, nxt;
    logic adv, load, step, wrap;
    logic [NZC_W-1:0] q_r, nzc_r, m, d, k, d_nxt, k_nxt;
    logic [RECIP_W-1:0] recip_r;
    logic [LEN_W-1:0] len_r, n;
    logic [PW-1:0] prod;
    logic [PHASE_W-1:0] zc, cs_ph;

    dmrs_mod_add #(.W(NZC_W)) u_d (.a(d), .b(q_r),   .n(nzc_r), .y(d_nxt));
    dmrs_mod_add #(.W(NZC_W)) u_k (.a(k), .b(d_nxt), .n(nzc_r), .y(k_nxt));

    assign prod = PW'(k) * PW'(recip_r);
    assign zc   = PHASE_W'((prod + HALF) >> SH);
    assign wrap = m + NZC_W'(1) == nzc_r;

    always_ff @(posedge clk)
        if (rst) st <= IDLE;
        else     st <= nxt;

    always_comb begin
        adv  = !phase_valid || phase_ready;
        load = st == LOAD;
        step = st == RUN && adv && !(phase_valid && last);
        nxt  = st == IDLE ? (start ? LOAD : IDLE) :
               st == LOAD ? (m_len == '0 ? DONE : RUN) :
               st == RUN  ? (adv && phase_valid && last ? DONE : RUN) : IDLE;
        busy = st != IDLE;
        done = st == DONE;
    end

    // Sample 0 is always phase 0, so LOAD emits it directly and primes the counters for n = 1.
    always_ff @(posedge clk)
        if (rst) begin
            q_r         <= '0;
            nzc_r       <= '0;
            recip_r     <= '0;
            len_r       <= '0;
            n           <= '0;
            m           <= '0;
            d           <= '0;
            k           <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            last        <= 1'b0;
        end else if (load) begin
            q_r         <= q;
            nzc_r       <= n_zc;
            recip_r     <= recip_nzc;
            len_r       <= m_len;
            n           <= LEN_W'(1);
            m           <= NZC_W'(1);
            d           <= q;
            k           <= q;
            phase       <= '0;
            phase_valid <= m_len != '0;
            last        <= m_len == LEN_W'(1);
        end else if (step) begin
            n           <= n + LEN_W'(1);
            m           <= wrap ? '0 : m + NZC_W'(1);
            d           <= wrap ? '0 : d_nxt;
            k           <= wrap ? '0 : k_nxt;
            phase       <= cs_ph - zc;
            phase_valid <= 1'b1;
            last        <= n == len_r - LEN_W'(1);
        end else if (st == RUN && adv) begin
            phase_valid <= 1'b0;
            last        <= 1'b0;
        end

`ifdef DMRS_PHASE_CS_EN
    logic [3:0] cs, ncs_r, cs_nxt;
    dmrs_mod_add #(.W(4)) u_cs (.a(cs), .b(ncs_r), .n(4'd12), .y(cs_nxt));
    assign cs_ph = PHASE_W'(CS_TAB[cs]);
    always_ff @(posedge clk)
        if (rst) begin
            cs    <= '0;
            ncs_r <= '0;
        end else if (load) begin
            cs    <= n_cs;
            ncs_r <= n_cs;
        end else if (step) begin
            cs    <= cs_nxt;
        end
`else
    logic unused_ncs;
    assign unused_ncs = ^n_cs;
    assign cs_ph = '0;
`endif
endmodule

// File: doc/dmrs_phase_gen.md
DMRS_PHASE_GEN -- requirements
Module: dmrs_phase_gen

Interface
REQ-001 SHALL have parameters: PHASE_W, default 15, phase width in turns (Q0.15). NZC_W, default 11, width of N_ZC, q and the modular state. LEN_W, default 12, width of the sequence length. RECIP_W, default 20, width of the 1/N_ZC reciprocal.
REQ-002 SHALL have ports, in this order:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a sequence.
- q  in  NZC_W  ZC root, 1..n_zc-1.
- n_zc  in  NZC_W  prime ZC length, 3..2039.
- recip_nzc  in  RECIP_W  round(2^RECIP_W / n_zc).
- m_len  in  LEN_W  number of samples to emit.
- n_cs  in  4  cyclic shift, 0..11.
- phase  out  PHASE_W  sample phase in turns, feeds the sin/cos LUT.
- phase_valid  out  1  phase holds a sample.
- phase_ready  in  1  downstream accepts.
- last  out  1  marks the final sample.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL emit phase(n) = (cs(n)*2^15/12 - k(m)*2^15/n_zc) mod 2^15, for n = 0..m_len-1, m = n mod n_zc, k(m) = q*m*(m+1)/2 mod n_zc, cs(n) = n*n_cs mod 12.
REQ-004 SHALL compute k incrementally with no multiplier or divider in the recursion:
- d(0) = k(0) = 0.
- d' = (d+q) mod n_zc.
- k' = (k+d') mod n_zc.
- Each modular add is one add plus one conditional subtract.
REQ-005 SHALL reset m, d and k to 0 when m+1 = n_zc (wrap-around). cs SHALL keep advancing across the wrap.
REQ-006 SHALL form the ZC phase as (k*recip_nzc) rounded to nearest, dropping RECIP_W-PHASE_W LSBs, then negate mod 2^PHASE_W.
REQ-007 SHALL use FSM IDLE -> LOAD -> RUN -> DONE -> IDLE:
- IDLE: on start, go to LOAD.
- LOAD: latch q, n_zc, recip_nzc, m_len and n_cs; clear the counters; go to RUN, or to DONE if m_len = 0.
- RUN: emit samples; after the sample with last is accepted, go to DONE.
- DONE: assert done for one cycle; go to IDLE.
REQ-008 SHALL assert the first phase_valid 2 cycles after the cycle in which start is sampled high.
REQ-009 SHALL register the phase output. The output register and the recursion advance only when !phase_valid || phase_ready.
REQ-010 SHALL hold phase, phase_valid and last stable while phase_valid && !phase_ready.
REQ-011 SHALL assert last together with the sample n = m_len-1. m_len = 0 SHALL produce done with no phase_valid.
REQ-012 SHALL ignore start in every state except IDLE. Input changes after LOAD SHALL NOT affect the sequence in flight.
REQ-013 SHALL keep the sample counter LEN_W wide. There is no overflow: m_len ≤ 2^LEN_W-1.

Reset
REQ-014 SHALL on rst enter IDLE and clear phase, phase_valid, last, busy, done and all counters to 0, from any state, including mid-RUN with a stalled output.
REQ-015 SHALL emit no phase_valid in the cycle after rst deasserts.

Configuration
REQ-016 With DMRS_PHASE_CS_EN defined, the block SHALL implement the cs counter (mod-12 add of n_cs) and a 12-entry Q0.15 cyclic-shift phase table.
REQ-017 Without DMRS_PHASE_CS_EN, the cs term SHALL be 0: n_cs is ignored and no cs logic is synthesised.

Structure
REQ-018 Package dmrs_pkg SHALL hold:
- the default widths;
- the FSM state enum;
- the 12-entry table round(i*32768/12), i = 0..11.
REQ-019 Sub-module dmrs_mod_add SHALL implement (a+b) mod n for a, b < n. It SHALL be instantiated for d, k and cs.

Verification
REQ-020 n_zc=31, q=1, recip=33825, m_len=4, n_cs=0, ready=1 -> phase 0, 31711, 29597, 26426; last on the 4th sample; done 1 cycle later.
REQ-021 n_zc=3, q=1, recip=349525, m_len=5 -> k 0, 1, 0, 0, 1; phase 0, 21845, 0, 0, 21845 (wrap at m=3).
REQ-022 DMRS_PHASE_CS_EN defined, n_zc=31, q=1, n_cs=3, m_len=2 -> phase 0, 7135.
REQ-023 phase_ready low for 3 cycles on sample 1 -> phase and valid held; the sequence resumes unchanged; total 4 accepted samples.
REQ-024 rst asserted mid-RUN during a stall -> next cycle all outputs 0 and busy 0. A new start then restarts from n=0. Start while busy is ignored.
REQ-025 m_len=0 -> done 2 cycles after start, phase_valid never asserted.
